// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - shared state and sensor-pair encodings for the parking gate
package gate_pkg;

  localparam logic [2:0] ENC_IDLE  = 3'd0;
  localparam logic [2:0] ENC_IN1   = 3'd1;
  localparam logic [2:0] ENC_IN2   = 3'd2;
  localparam logic [2:0] ENC_IN3   = 3'd3;
  localparam logic [2:0] ENC_OUT1  = 3'd4;
  localparam logic [2:0] ENC_OUT2  = 3'd5;
  localparam logic [2:0] ENC_OUT3  = 3'd6;
  localparam logic [2:0] ENC_FAULT = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = ENC_IDLE,
    ST_IN1   = ENC_IN1,
    ST_IN2   = ENC_IN2,
    ST_IN3   = ENC_IN3,
    ST_OUT1  = ENC_OUT1,
    ST_OUT2  = ENC_OUT2,
    ST_OUT3  = ENC_OUT3,
    ST_FAULT = ENC_FAULT
  } gate_state_e;

  // Sensor pair is {outer a, inner b}, 1 = beam blocked
  localparam logic [1:0] PAIR_CLEAR  = 2'b00;
  localparam logic [1:0] PAIR_B_ONLY = 2'b01;
  localparam logic [1:0] PAIR_A_ONLY = 2'b10;
  localparam logic [1:0] PAIR_BOTH   = 2'b11;

endpackage

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - per-sensor debounce, raw must hold DEBOUNCE_CYCLES samples
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic raw,
  output logic deb
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_deb;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt <= '0;
      r_deb <= 1'b0;
    end else if (raw == r_deb) begin
      r_cnt <= '0;
    end else if (r_cnt == CNT_LAST) begin
      r_deb <= raw;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign deb = r_deb;

endmodule

// File: rtl/gate_sensor_decoder.sv
// rtl/gate_sensor_decoder.sv - decodes debounced beam order into entry/exit pulses and fault
module gate_sensor_decoder
  import gate_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic clk,
  input  logic clr,
  input  logic sens_a,
  input  logic sens_b,
  output logic ent,
  output logic ext,
  output logic fault
);

  localparam int DW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(TIMEOUT_CYCLES - 1);
  localparam logic [DW-1:0] DWELL_MAX  = DW'(TIMEOUT_CYCLES);

  logic          w_deb_a;
  logic          w_deb_b;
  logic [1:0]    w_pair;
  gate_state_e   r_state;
  gate_state_e   w_next;
  logic          w_ent;
  logic          w_ext;
  logic          w_timeout;
  logic [DW-1:0] r_dwell;
  logic          r_ent;
  logic          r_ext;
  logic          r_fault;

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk(clk), .clr(clr), .raw(sens_a), .deb(w_deb_a)
  );

  sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk(clk), .clr(clr), .raw(sens_b), .deb(w_deb_b)
  );

  assign w_pair    = {w_deb_a, w_deb_b};
  assign w_timeout = (r_dwell >= DWELL_LAST);

  always_comb begin
    w_next = r_state;
    w_ent  = 1'b0;
    w_ext  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        case (w_pair)
          PAIR_A_ONLY: w_next = ST_IN1;
          PAIR_B_ONLY: w_next = ST_OUT1;
          PAIR_BOTH:   w_next = ST_FAULT;
          default:     w_next = ST_IDLE;
        endcase
      end
      ST_IN1: begin
        case (w_pair)
          PAIR_A_ONLY: w_next = ST_IN1;
          PAIR_BOTH:   w_next = ST_IN2;
          PAIR_CLEAR:  w_next = ST_IDLE;
          default:     w_next = ST_FAULT;
        endcase
      end
      ST_IN2: begin
        case (w_pair)
          PAIR_BOTH:   w_next = ST_IN2;
          PAIR_B_ONLY: w_next = ST_IN3;
          PAIR_A_ONLY: w_next = ST_IN1;
          default:     w_next = ST_FAULT;
        endcase
      end
      ST_IN3: begin
        case (w_pair)
          PAIR_B_ONLY: w_next = ST_IN3;
          PAIR_CLEAR: begin
            w_next = ST_IDLE;
            w_ent  = 1'b1;
          end
          PAIR_BOTH:   w_next = ST_IN2;
          default:     w_next = ST_FAULT;
        endcase
      end
      ST_OUT1: begin
        case (w_pair)
          PAIR_B_ONLY: w_next = ST_OUT1;
          PAIR_BOTH:   w_next = ST_OUT2;
          PAIR_CLEAR:  w_next = ST_IDLE;
          default:     w_next = ST_FAULT;
        endcase
      end
      ST_OUT2: begin
        case (w_pair)
          PAIR_BOTH:   w_next = ST_OUT2;
          PAIR_A_ONLY: w_next = ST_OUT3;
          PAIR_B_ONLY: w_next = ST_OUT1;
          default:     w_next = ST_FAULT;
        endcase
      end
      ST_OUT3: begin
        case (w_pair)
          PAIR_A_ONLY: w_next = ST_OUT3;
          PAIR_CLEAR: begin
            w_next = ST_IDLE;
            w_ext  = 1'b1;
          end
          PAIR_BOTH:   w_next = ST_OUT2;
          default:     w_next = ST_FAULT;
        endcase
      end
      ST_FAULT: begin
        if (w_pair == PAIR_CLEAR) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    // A legitimate sensor change wins; timeout only fires while the car is stalled
    if (w_next == r_state && r_state != ST_IDLE && r_state != ST_FAULT && w_timeout) begin
      w_next = ST_FAULT;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= ST_IDLE;
      r_dwell <= '0;
      r_ent   <= 1'b0;
      r_ext   <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_dwell <= '0;
      else if (r_dwell != DWELL_MAX) r_dwell <= r_dwell + 1'b1;
      r_ent   <= w_ent;
      r_ext   <= w_ext;
      r_fault <= (w_next == ST_FAULT);
    end
  end

  assign ent   = r_ent;
  assign ext   = r_ext;
  assign fault = r_fault;

endmodule

// File: tb/tb_gate_sensor_decoder.sv
// tb/tb_gate_sensor_decoder.sv - directed scoreboard bench for gate_sensor_decoder
module tb_gate_sensor_decoder;
  import gate_pkg::*;

  localparam int DEB = 4;
  localparam int TMO = 20;
  localparam int LAT = DEB + 1;

  localparam int EV_NONE = 0;
  localparam int EV_ENT  = 1;
  localparam int EV_EXT  = 2;
  localparam int EV_RISE = 3;
  localparam int EV_FALL = 4;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic sens_a = 1'b0;
  logic sens_b = 1'b0;
  logic ent;
  logic ext;
  logic fault;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic prev_fault = 1'b0;
  exp_t q[$];

  gate_sensor_decoder #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .clr(clr), .sens_a(sens_a), .sens_b(sens_b),
    .ent(ent), .ext(ext), .fault(fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input int obs, input int exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  task automatic got_event(input int kind);
    exp_t e;
    if (q.size() > 0) e = q.pop_front();
    else e = '{kind: EV_NONE, cyc: -1};
    chk("event_kind", kind, e.kind);
    chk("event_cycle", cyc, e.cyc);
  endtask

  always @(negedge clk) begin
    if (ent || ext) chk("ent_ext_exclusive", int'(ent & ext), 0);
    if (ent) got_event(EV_ENT);
    if (ext) got_event(EV_EXT);
    if (fault && !prev_fault) got_event(EV_RISE);
    if (!fault && prev_fault) got_event(EV_FALL);
    prev_fault = fault;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic b, input int ev, input int lat);
    sens_a = a;
    sens_b = b;
    if (ev != EV_NONE) q.push_back('{kind: ev, cyc: cyc + lat});
  endtask

  task automatic phase(input logic a, input logic b, input int ev);
    drive(a, b, ev, LAT);
    tick(10);
  endtask

  initial begin
    clr = 1'b1;
    tick(2);
    chk("reset_state", int'(dut.r_state), int'(ST_IDLE));
    chk("reset_ent", int'(ent), 0);
    chk("reset_ext", int'(ext), 0);
    chk("reset_fault", int'(fault), 0);
    clr = 1'b0;

    // entry
    phase(1'b1, 1'b0, EV_NONE);
    chk("entry_in1", int'(dut.r_state), int'(ST_IN1));
    phase(1'b1, 1'b1, EV_NONE);
    phase(1'b0, 1'b1, EV_NONE);
    chk("entry_in3", int'(dut.r_state), int'(ST_IN3));
    phase(1'b0, 1'b0, EV_ENT);
    chk("entry_idle", int'(dut.r_state), int'(ST_IDLE));

    // exit
    phase(1'b0, 1'b1, EV_NONE);
    chk("exit_out1", int'(dut.r_state), int'(ST_OUT1));
    phase(1'b1, 1'b1, EV_NONE);
    phase(1'b1, 1'b0, EV_NONE);
    chk("exit_out3", int'(dut.r_state), int'(ST_OUT3));
    phase(1'b0, 1'b0, EV_EXT);

    // 2-cycle glitch on a
    drive(1'b1, 1'b0, EV_NONE, 0);
    tick(2);
    phase(1'b0, 1'b0, EV_NONE);
    chk("glitch_idle", int'(dut.r_state), int'(ST_IDLE));

    // back-outs
    phase(1'b1, 1'b0, EV_NONE);
    phase(1'b0, 1'b0, EV_NONE);
    chk("backout1_idle", int'(dut.r_state), int'(ST_IDLE));
    phase(1'b1, 1'b0, EV_NONE);
    phase(1'b1, 1'b1, EV_NONE);
    phase(1'b1, 1'b0, EV_NONE);
    chk("backout2_in1", int'(dut.r_state), int'(ST_IN1));
    phase(1'b0, 1'b0, EV_NONE);
    chk("backout2_idle", int'(dut.r_state), int'(ST_IDLE));

    // both rising from idle
    phase(1'b1, 1'b1, EV_RISE);
    chk("both_fault", int'(fault), 1);
    phase(1'b0, 1'b0, EV_FALL);
    chk("both_cleared", int'(fault), 0);

    // dwell timeout in IN1
    drive(1'b1, 1'b0, EV_RISE, LAT + TMO);
    tick(30);
    chk("timeout_fault", int'(fault), 1);
    phase(1'b0, 1'b0, EV_FALL);

    // reset while in IN3, b still blocked on release
    phase(1'b1, 1'b0, EV_NONE);
    phase(1'b1, 1'b1, EV_NONE);
    phase(1'b0, 1'b1, EV_NONE);
    chk("midreset_in3", int'(dut.r_state), int'(ST_IN3));
    clr = 1'b1;
    tick(1);
    chk("midreset_state", int'(dut.r_state), int'(ST_IDLE));
    chk("midreset_outs", int'({ent, ext, fault}), 0);
    tick(1);
    clr = 1'b0;
    tick(4);
    chk("release_wait", int'(dut.r_state), int'(ST_IDLE));
    tick(1);
    chk("release_out1", int'(dut.r_state), int'(ST_OUT1));
    phase(1'b0, 1'b0, EV_NONE);
    chk("release_idle", int'(dut.r_state), int'(ST_IDLE));

    tick(5);
    chk("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
